shared_reg_arbiter: RTL

- Round-robin arbiter that shares one DATA_W-bit register, built from synchronous-reset D flip-flops, among NUM_REQ write requesters.
- Exactly one write, or none, is committed to the shared register each clock.
- The winning requester receives a one-cycle acknowledge.
- Sits between several producer blocks and a single shared configuration/status register.

---
 rtl/shared_reg_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_reg_arbiter
//  Purpose  : Round-robin arbiter that lets NUM_REQ producers share a single
//             DATA_W-bit register. At most one write commits per clock; the
//             winner receives a registered one-cycle acknowledge.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             clr           - synchronous clear of the shared register
//                             (beats any write, requests stay pending)
//             req[N]        - level write requests
//             wdata[N*W]    - packed write data, requester i at [i*W +: W]
//             ack[N]        - registered one-hot/zero commit pulse
//             q, q_valid    - shared register contents and its valid flag
//             last_id       - index of requester that produced q
//             wr_count      - committed writes since reset (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    wdata,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DATA_W-1:0]            q,
    output logic                         q_valid,
    output logic [$clog2(NUM_REQ)-1:0]   last_id,
    output logic [CNT_W-1:0]             wr_count
);

    localparam int              ID_W  = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   c_NUM = (ID_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_q;
    logic                r_q_valid;
    logic [ID_W-1:0]     r_last_id;
    logic [CNT_W-1:0]    r_wr_count;
    logic [ID_W-1:0]     r_ptr;

    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [ID_W:0]       w_idx;
    logic [ID_W:0]       w_win_p1;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [DATA_W-1:0]   w_wdata_win;

    // A requester acked last cycle sits out one cycle so it can drop req
    // after seeing ack without being granted twice for one write.
    assign w_elig = req & ~r_ack;

    // Rotating priority search: offsets 0..N-1 from ptr, modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= c_NUM) begin
                w_idx = w_idx - c_NUM;
            end
            if (!w_found && w_elig[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[ID_W-1:0];
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next.
    always_comb begin
        w_win_p1  = {1'b0, w_win} + (ID_W+1)'(1);
        w_ptr_nxt = w_win_p1[ID_W-1:0];
        if (w_win_p1 == c_NUM) begin
            w_ptr_nxt = '0;
        end
    end

    // Winner's data slice and one-hot ack vector.
    always_comb begin
        w_onehot    = '0;
        w_wdata_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_wdata_win = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack      <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_last_id  <= '0;
            r_wr_count <= '0;
            r_ptr      <= '0;
        end else if (clr) begin
            // Clear wins over any write; last_id, ptr and count hold.
            r_ack      <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
        end else if (w_found) begin
            r_ack      <= w_onehot;
            r_q        <= w_wdata_win;
            r_q_valid  <= 1'b1;
            r_last_id  <= w_win;
            r_wr_count <= r_wr_count + CNT_W'(1);
            r_ptr      <= w_ptr_nxt;
        end else begin
            r_ack      <= '0;
        end
    end

    assign ack      = r_ack;
    assign q        = r_q;
    assign q_valid  = r_q_valid;
    assign last_id  = r_last_id;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire
